fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequencing controller for the instruction-fetch stage.
- Owns the program counter and arbitrates the single instruction-memory port between a boot loader (writes program words) and instruction fetch (reads).
- Fetch honours hazard stalls and branch redirects (PCSrc/target from MEM stage), flushes the IF/ID register on redirect, and halts on a HALT opcode.
- Sits between the instruction memory, the IF/ID pipeline register and the hazard/branch logic.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- PC_INC, 16'd4, PC increment per fetched instruction (matches the PC+4 adder convention).
- HALT_OPCODE, 4'hF, value of instruction bits [15:12] that halts fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- loadValid  in  1  loader presents a program word.
- loadAddr  in  16  loader write address.
- loadData  in  16  loader write data.
- loadDone  in  1  loader finished; start fetching.
- loadReady  out  1  word accepted this cycle.
- stall  in  1  hazard unit holds IF/ID.
- PCSrc  in  1  branch taken, redirect fetch.
- branchTarget  in  16  redirect address.
- memAddr  out  16  instruction-memory address.
- memRead  out  1  read request.
- memWrite  out  1  write request.
- memWData  out  16  write data.
- memReady  in  1  memory completes the current access this cycle.
- memData  in  16  read data, valid with memReady.
- outputPC4  out  16  PC+PC_INC of presented instruction.
- outputInstr  out  16  presented instruction.
- instrValid  out  1  outputInstr/outputPC4 valid.
- flush  out  1  one-cycle IF/ID flush pulse.
- halted  out  1  fetch stopped.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=LOAD, pc=RESET_PC, discard flag=0.
  - Registered outputs cleared: outputPC4=0, outputInstr=0, instrValid=0, flush=0, halted=0.
  - memRead=0 and memWrite=0 immediately, even mid-access.
- **States:** LOAD, FETCH_REQ, FETCH_WAIT, HOLD, HALTED.
- **LOAD:**
  - memWrite=loadValid, memAddr=loadAddr, memWData=loadData, loadReady=loadValid&memReady (all combinational). A word is written on an edge where loadReady=1.
  - loadDone with loadValid=0 -> FETCH_REQ. If loadValid is also high, the write completes first and loadDone is acted on only once loadValid=0.
  - PCSrc and stall are ignored.
- **FETCH_REQ:** memRead=1, memAddr=pc; next state FETCH_WAIT.
- **FETCH_WAIT:**
  - memRead=1 and memAddr=pc held stable until memReady.
  - On memReady, with discard=0 and memData[15:12]!=HALT_OPCODE: outputInstr<=memData, outputPC4<=pc+PC_INC, instrValid<=1, pc<=pc+PC_INC -> HOLD.
  - On memReady with the HALT opcode: instrValid stays 0, pc unchanged, halted<=1 -> HALTED.
  - On memReady with discard=1: data dropped, discard<=0 -> FETCH_REQ.
- **HOLD:**
  - The instruction is consumed on an edge with stall=0 -> instrValid<=0 -> FETCH_REQ.
  - With stall=1, all outputs hold.
- **Redirect (PCSrc=1 in FETCH_REQ/FETCH_WAIT/HOLD):** PCSrc has priority over stall and over capture.
  - pc<=branchTarget, flush<=1 for exactly one cycle, instrValid<=0.
  - In FETCH_WAIT without memReady: discard<=1, and memAddr is held at the old pc until that access completes.
  - In FETCH_WAIT with memReady in the same cycle: the data is dropped -> FETCH_REQ.
  - In FETCH_REQ/HOLD: -> FETCH_REQ.
  - A second PCSrc while discard=1 overwrites pc only.
- **HALTED:** memRead=0, halted=1. PCSrc, stall and loadValid are ignored; only reset exits.
- **Arithmetic:** pc+PC_INC wraps modulo 2^16 (16'hFFFC+4=16'h0000). No other overflow handling.
- **Throughput:** minimum 3 cycles per instruction (REQ, WAIT with memReady, HOLD with stall=0).

Test Plan:
1. **Load then fetch:**
   - Stimulus: reset low 2 cycles; load 16'h1234@0 and 16'h5678@4; loadDone; memory replies memReady one cycle after each request.
   - Response: instrValid with outputInstr=16'h1234/outputPC4=16'h0004, then 16'h5678/16'h0008.
2. **Stall hold:**
   - Stimulus: stall=1 for 4 cycles while in HOLD with 16'h1234.
   - Response: outputs and instrValid unchanged for those 4 cycles; memRead=0; the next fetch addresses 16'h0004 only after stall drops.
3. **Redirect during wait:**
   - Stimulus: PCSrc=1, branchTarget=16'h0040 while memReady is low in FETCH_WAIT.
   - Response: flush pulses one cycle; the in-flight data is not presented; the next memAddr with memRead=1 is 16'h0040.
4. **Redirect vs stall:**
   - Stimulus: PCSrc=1 and stall=1 together in HOLD.
   - Response: instrValid=0 next cycle; flush=1; fetch resumes at branchTarget.
5. **Halt:**
   - Stimulus: fetched word 16'hF000.
   - Response: halted=1, instrValid stays 0, memRead stays 0; a subsequent PCSrc has no effect.
6. **Wrap and mid-access reset:**
   - Stimulus: start with RESET_PC=16'hFFFC.
   - Response: outputPC4=16'h0000, and the next fetch is at 0.
   - Stimulus: reset asserted mid-FETCH_WAIT.
   - Response: memRead drops immediately and state returns to LOAD.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencing controller.
// Owns the program counter and shares the single instruction-memory port
// between the boot loader (writes) and instruction fetch (reads). Fetch
// honours hazard stalls, branch redirects with an IF/ID flush pulse, and
// stops permanently on a HALT opcode until the next reset.
module fetch_controller #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_INC      = 16'd4,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadValid,
  input  logic [15:0] loadAddr,
  input  logic [15:0] loadData,
  input  logic        loadDone,
  output logic        loadReady,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [15:0] branchTarget,
  output logic [15:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] memWData,
  input  logic        memReady,
  input  logic [15:0] memData,
  output logic [15:0] outputPC4,
  output logic [15:0] outputInstr,
  output logic        instrValid,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_HOLD       = 3'd3,
    ST_HALTED     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;
  logic [15:0] pc4_q, pc4_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_next_seq;
  logic        is_halt_word;

  // Sequential PC successor wraps naturally at 16 bits.
  assign pc_next_seq  = pc_q + PC_INC;
  assign is_halt_word = (memData[15:12] == HALT_OPCODE);

  assign outputPC4   = pc4_q;
  assign outputInstr = instr_q;
  assign instrValid  = valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

  // Next-state, next-register and memory-port decode for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    pc4_d      = pc4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    halted_d   = halted_q;
    memAddr    = pc_q;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memWData   = 16'h0000;
    loadReady  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        memWrite  = loadValid;
        memAddr   = loadAddr;
        memWData  = loadData;
        loadReady = loadValid & memReady;
        // A pending write always finishes before fetch is allowed to start.
        if (loadDone && !loadValid) begin
          state_d = ST_FETCH_REQ;
        end
      end

      ST_FETCH_REQ: begin
        memRead    = 1'b1;
        memAddr    = pc_q;
        req_addr_d = pc_q;
        if (PCSrc) begin
          pc_d    = branchTarget;
          flush_d = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH_REQ;
        end else begin
          state_d = ST_FETCH_WAIT;
        end
      end

      ST_FETCH_WAIT: begin
        memRead = 1'b1;
        // The address latched at request time stays on the bus even after a
        // redirect has already moved pc, so the memory sees a stable access.
        memAddr = req_addr_q;
        if (memReady) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH_REQ;
            if (PCSrc) begin
              pc_d = branchTarget;
            end
          end else if (PCSrc) begin
            pc_d    = branchTarget;
            flush_d = 1'b1;
            valid_d = 1'b0;
            state_d = ST_FETCH_REQ;
          end else if (is_halt_word) begin
            halted_d = 1'b1;
            valid_d  = 1'b0;
            state_d  = ST_HALTED;
          end else begin
            instr_d = memData;
            pc4_d   = pc_next_seq;
            valid_d = 1'b1;
            pc_d    = pc_next_seq;
            state_d = ST_HOLD;
          end
        end else if (PCSrc) begin
          pc_d = branchTarget;
          if (!discard_q) begin
            flush_d   = 1'b1;
            valid_d   = 1'b0;
            discard_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (PCSrc) begin
          pc_d    = branchTarget;
          flush_d = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = ST_FETCH_REQ;
        end
      end

      ST_HALTED: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and datapath registers; reset also kills any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
      pc4_q      <= 16'h0000;
      instr_q    <= 16'h0000;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      pc4_q      <= pc4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: scoreboard bench for fetch_controller. A behavioural
// instruction memory answers reads after a programmable latency; expected
// presentations are queued as each program is loaded and popped as the
// controller presents instructions.
module tb_fetch_controller;

  logic        clock;
  logic        reset;
  logic        loadValid;
  logic [15:0] loadAddr;
  logic [15:0] loadData;
  logic        loadDone;
  logic        loadReady;
  logic        stall;
  logic        PCSrc;
  logic [15:0] branchTarget;
  logic [15:0] memAddr;
  logic        memRead;
  logic        memWrite;
  logic [15:0] memWData;
  logic        memReady;
  logic [15:0] memData;
  logic [15:0] outputPC4;
  logic [15:0] outputInstr;
  logic        instrValid;
  logic        flush;
  logic        halted;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   lat;
  int   rd_cnt;

  logic [15:0] mem [0:65535];

  fetch_controller dut (
    .clock       (clock),
    .reset       (reset),
    .loadValid   (loadValid),
    .loadAddr    (loadAddr),
    .loadData    (loadData),
    .loadDone    (loadDone),
    .loadReady   (loadReady),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .branchTarget(branchTarget),
    .memAddr     (memAddr),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memWData    (memWData),
    .memReady    (memReady),
    .memData     (memData),
    .outputPC4   (outputPC4),
    .outputInstr (outputInstr),
    .instrValid  (instrValid),
    .flush       (flush),
    .halted      (halted)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Writes complete immediately; reads complete once the request has been
  // held for lat cycles.
  assign memReady = memWrite | (memRead & (rd_cnt >= lat));
  assign memData  = mem[memAddr];

  // Count how long the current read has been outstanding.
  always @(posedge clock or negedge reset) begin
    if (!reset) rd_cnt <= 0;
    else if (memRead && !memReady) rd_cnt <= rd_cnt + 1;
    else rd_cnt <= 0;
  end

  // Memory array write port.
  always @(posedge clock) begin
    if (memWrite && memReady) mem[memAddr] <= memWData;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    loadValid    = 1'b0;
    loadAddr     = 16'h0000;
    loadData     = 16'h0000;
    loadDone     = 1'b0;
    stall        = 1'b0;
    PCSrc        = 1'b0;
    branchTarget = 16'h0000;
    lat          = 1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    loadValid = 1'b1;
    loadAddr  = a;
    loadData  = d;
    tick();
  endtask

  task automatic start_fetch();
    loadValid = 1'b0;
    loadDone  = 1'b1;
    tick();
    loadDone = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] instr, input logic [15:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    sb.push_back(e);
  endtask

  task automatic wait_present(input string name);
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (instrValid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: no instruction presented within 30 cycles", name);
    end else if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: unexpected presentation instr=%h pc4=%h", name, outputInstr, outputPC4);
    end else begin
      e = sb.pop_front();
      if (outputInstr !== e.instr) begin
        errors++;
        $display("[TB] FAIL %s instr: got %h want %h", name, outputInstr, e.instr);
      end
      checks++;
      if (outputPC4 !== e.pc4) begin
        errors++;
        $display("[TB] FAIL %s pc4: got %h want %h", name, outputPC4, e.pc4);
      end
    end
  endtask

  task automatic wait_halt(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (halted === 1'b1) seen = 1'b1;
      else if (instrValid === 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: unexpected presentation instr=%h before halt", name, outputInstr);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: halted got %b want 1 within 30 cycles", name, halted);
    end
    checks++;
    if (instrValid !== 1'b0 || memRead !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s halted outputs: instrValid=%b memRead=%b want 0/0", name, instrValid, memRead);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset     = 1'b0;
    loadValid = 1'b0;
    loadDone  = 1'b0;
    stall     = 1'b0;
    PCSrc     = 1'b0;
    lat       = 1;
    repeat (2) tick();
    checks++;
    if ({instrValid, flush, halted, memRead, memWrite} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset flags: got %b want 00000", {instrValid, flush, halted, memRead, memWrite});
    end
    checks++;
    if (outputPC4 !== 16'h0000 || outputInstr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset data: pc4=%h instr=%h want 0000/0000", outputPC4, outputInstr);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_fetch();
    $display("[TB] test_load_fetch");
    do_reset();
    loadValid = 1'b1;
    loadAddr  = 16'h0000;
    loadData  = 16'h1234;
    #1;
    checks++;
    if (loadReady !== 1'b1 || memWrite !== 1'b1 || memAddr !== 16'h0000 || memWData !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL load port: ready=%b wr=%b addr=%h wdata=%h want 1/1/0000/1234", loadReady, memWrite, memAddr, memWData);
    end
    tick();
    load_word(16'h0004, 16'h5678);
    load_word(16'h0008, 16'hF000);
    start_fetch();
    push_exp(16'h1234, 16'h0004);
    push_exp(16'h5678, 16'h0008);
    wait_present("load_fetch first");
    wait_present("load_fetch second");
    wait_halt("load_fetch halt");
  endtask

  task automatic test_stall_hold();
    $display("[TB] test_stall_hold");
    do_reset();
    load_word(16'h0000, 16'h1234);
    load_word(16'h0004, 16'h5678);
    load_word(16'h0008, 16'hF000);
    stall = 1'b1;
    start_fetch();
    push_exp(16'h1234, 16'h0004);
    wait_present("stall first");
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instrValid !== 1'b1 || outputInstr !== 16'h1234 || outputPC4 !== 16'h0004 || memRead !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall hold cycle %0d: valid=%b instr=%h pc4=%h rd=%b want 1/1234/0004/0", i, instrValid, outputInstr, outputPC4, memRead);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (memRead !== 1'b1 || memAddr !== 16'h0004 || instrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall release: rd=%b addr=%h valid=%b want 1/0004/0", memRead, memAddr, instrValid);
    end
    push_exp(16'h5678, 16'h0008);
    wait_present("stall second");
    wait_halt("stall halt");
  endtask

  task automatic test_redirect_wait();
    $display("[TB] test_redirect_wait");
    do_reset();
    load_word(16'h0000, 16'h1234);
    load_word(16'h0040, 16'hABCD);
    load_word(16'h0044, 16'hF000);
    lat = 100;
    start_fetch();
    tick();
    checks++;
    if (memRead !== 1'b1 || memAddr !== 16'h0000 || memReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect pre-wait: rd=%b addr=%h rdy=%b want 1/0000/0", memRead, memAddr, memReady);
    end
    PCSrc        = 1'b1;
    branchTarget = 16'h0040;
    tick();
    PCSrc = 1'b0;
    checks++;
    if (flush !== 1'b1 || memRead !== 1'b1 || memAddr !== 16'h0000 || instrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect wait: flush=%b rd=%b addr=%h valid=%b want 1/1/0000/0", flush, memRead, memAddr, instrValid);
    end
    lat = 1;
    tick();
    checks++;
    if (flush !== 1'b0 || memRead !== 1'b1 || memAddr !== 16'h0040 || instrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect refetch: flush=%b rd=%b addr=%h valid=%b want 0/1/0040/0", flush, memRead, memAddr, instrValid);
    end
    push_exp(16'hABCD, 16'h0044);
    wait_present("redirect target");
    wait_halt("redirect halt");
  endtask

  task automatic test_redirect_stall();
    $display("[TB] test_redirect_stall");
    do_reset();
    load_word(16'h0000, 16'h1111);
    load_word(16'h0080, 16'h2222);
    load_word(16'h0084, 16'hF000);
    stall = 1'b1;
    start_fetch();
    push_exp(16'h1111, 16'h0004);
    wait_present("redirect_stall first");
    PCSrc        = 1'b1;
    branchTarget = 16'h0080;
    tick();
    PCSrc = 1'b0;
    stall = 1'b0;
    checks++;
    if (instrValid !== 1'b0 || flush !== 1'b1 || memRead !== 1'b1 || memAddr !== 16'h0080) begin
      errors++;
      $display("[TB] FAIL redirect over stall: valid=%b flush=%b rd=%b addr=%h want 0/1/1/0080", instrValid, flush, memRead, memAddr);
    end
    push_exp(16'h2222, 16'h0084);
    wait_present("redirect_stall target");
    wait_halt("redirect_stall halt");
  endtask

  task automatic test_halt();
    $display("[TB] test_halt");
    do_reset();
    load_word(16'h0000, 16'hF000);
    load_word(16'h0020, 16'h3333);
    start_fetch();
    wait_halt("halt");
    PCSrc        = 1'b1;
    branchTarget = 16'h0020;
    stall        = 1'b1;
    loadValid    = 1'b1;
    loadAddr     = 16'h0020;
    loadData     = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || memRead !== 1'b0 || memWrite !== 1'b0 || instrValid !== 1'b0 || flush !== 1'b0) begin
        errors++;
        $display("[TB] FAIL halt sticky %0d: halted=%b rd=%b wr=%b valid=%b flush=%b want 1/0/0/0/0", i, halted, memRead, memWrite, instrValid, flush);
      end
    end
    PCSrc     = 1'b0;
    stall     = 1'b0;
    loadValid = 1'b0;
  endtask

  task automatic test_wrap_reset();
    $display("[TB] test_wrap_reset");
    do_reset();
    load_word(16'h0000, 16'h5555);
    load_word(16'hFFFC, 16'h3333);
    stall = 1'b1;
    start_fetch();
    push_exp(16'h5555, 16'h0004);
    wait_present("wrap first");
    PCSrc        = 1'b1;
    branchTarget = 16'hFFFC;
    tick();
    PCSrc = 1'b0;
    stall = 1'b0;
    push_exp(16'h3333, 16'h0000);
    wait_present("wrap top");
    tick();
    checks++;
    if (memRead !== 1'b1 || memAddr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap next fetch: rd=%b addr=%h want 1/0000", memRead, memAddr);
    end
    push_exp(16'h5555, 16'h0004);
    wait_present("wrap zero");
    lat = 100;
    tick();
    tick();
    checks++;
    if (memRead !== 1'b1 || memAddr !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL mid-access setup: rd=%b addr=%h want 1/0004", memRead, memAddr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (memRead !== 1'b0 || instrValid !== 1'b0 || outputPC4 !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async reset: rd=%b valid=%b pc4=%h halted=%b want 0/0/0000/0", memRead, instrValid, outputPC4, halted);
    end
    loadValid = 1'b1;
    loadAddr  = 16'h0010;
    loadData  = 16'h7777;
    #1;
    checks++;
    if (memWrite !== 1'b1 || memAddr !== 16'h0010 || memWData !== 16'h7777 || loadReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset returns to load: wr=%b addr=%h wdata=%h ready=%b want 1/0010/7777/1", memWrite, memAddr, memWData, loadReady);
    end
    loadValid = 1'b0;
    lat       = 1;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    loadValid    = 1'b0;
    loadAddr     = 16'h0000;
    loadData     = 16'h0000;
    loadDone     = 1'b0;
    stall        = 1'b0;
    PCSrc        = 1'b0;
    branchTarget = 16'h0000;
    lat          = 1;
    test_reset();
    test_load_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall();
    test_halt();
    test_wrap_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
